// File: rtl/fifo_256x256_frame_if.sv
// Request/response bundle for the frame FIFO: one enable, a direction bit and the data/status lines.
// The master drives the request; the slave (the FIFO) returns registered data and count-derived flags.
interface fifo_256x256_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  en;
    logic                  push_pop;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  full_signal;
    logic                  empty_signal;

    modport master (
        output en,
        output push_pop,
        output DATA_IN,
        input  DATA_OUT,
        input  full_signal,
        input  empty_signal
    );

    modport slave (
        input  en,
        input  push_pop,
        input  DATA_IN,
        output DATA_OUT,
        output full_signal,
        output empty_signal
    );
endinterface

// File: rtl/fifo_256x256_frame.sv
// Purpose: single-clock FIFO holding one 256x256 frame of grey pixels; option FIFO_ZERO_ON_EMPTY_POP_EN.
// Latency: popped word appears on DATA_OUT right after the accepting edge; flags decode the registered count.
// Backpressure: push while full and pop while empty are silently dropped; the source watches the flags.
module fifo_256x256_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input logic                   clk,
    input logic                   reset,
    fifo_256x256_frame_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Count has one extra bit so a completely full frame is distinguishable from empty.
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_req;
    logic pop_ok;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        push_ok = bus.en && bus.push_pop && !full;
        pop_req = bus.en && !bus.push_pop;
        pop_ok  = pop_req && !empty;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            count_d  = count_q + (ADDR_WIDTH+1)'(1);
        end else if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            count_d    = count_q - (ADDR_WIDTH+1)'(1);
            data_out_d = mem[rd_ptr_q];
        end
`ifdef FIFO_ZERO_ON_EMPTY_POP_EN
        else if (pop_req) begin
            data_out_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.DATA_IN;
        end
    end

    assign bus.DATA_OUT     = data_out_q;
    assign bus.full_signal  = full;
    assign bus.empty_signal = empty;
endmodule

// File: tb/tb_fifo_256x256_frame.sv
// Bench for fifo_256x256_frame: full-size frame instance plus a 256-deep instance for quick drain/wrap runs.
module tb_fifo_256x256_frame;
    localparam int DEPTH_B = 65536;
    localparam int DEPTH_S = 256;
`ifdef FIFO_ZERO_ON_EMPTY_POP_EN
    localparam logic [7:0] EMPTY_POP_VAL = 8'h00;
`else
    localparam logic [7:0] EMPTY_POP_VAL = 8'hFF;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_256x256_frame_if #(.DATA_WIDTH(8)) bb ();
    fifo_256x256_frame_if #(.DATA_WIDTH(8)) sb ();

    fifo_256x256_frame #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bb)
    );

    fifo_256x256_frame #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (sb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] qb[$];
    logic [7:0] qs[$];
    logic [7:0] lastb = 8'h00;
    logic [7:0] lasts = 8'h00;

    // One clock of the full-size FIFO: drive, then apply the FIFO rules to the queue model.
    task automatic cyc_b(input logic e, input logic p, input logic [7:0] d);
        bb.en = e; bb.push_pop = p; bb.DATA_IN = d;
        @(posedge clk);
        if (e && p) begin
            if (qb.size() < DEPTH_B) qb.push_back(d);
        end else if (e) begin
            if (qb.size() > 0) lastb = qb.pop_front();
            else lastb = (EMPTY_POP_VAL == 8'h00) ? 8'h00 : lastb;
        end
        @(negedge clk);
    endtask

    task automatic cyc_s(input logic e, input logic p, input logic [7:0] d);
        sb.en = e; sb.push_pop = p; sb.DATA_IN = d;
        @(posedge clk);
        if (e && p) begin
            if (qs.size() < DEPTH_S) qs.push_back(d);
        end else if (e) begin
            if (qs.size() > 0) lasts = qs.pop_front();
            else lasts = (EMPTY_POP_VAL == 8'h00) ? 8'h00 : lasts;
        end
        @(negedge clk);
    endtask

    // Called at a falling edge; reset is raised and dropped well before the next rising edge.
    task automatic pulse_reset();
        bb.en = 1'b0; sb.en = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        qb.delete(); qs.delete();
        lastb = 8'h00; lasts = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bb.en = 1'b0; bb.push_pop = 1'b0; bb.DATA_IN = 8'h00;
        sb.en = 1'b0; sb.push_pop = 1'b0; sb.DATA_IN = 8'h00;
        #7 reset = 1'b1;
        #1;
        n_checks++; if (bb.DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bb.DATA_OUT); end
        n_checks++; if (bb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bb.empty_signal); end
        n_checks++; if (bb.full_signal !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bb.full_signal); end
        n_checks++; if (sb.DATA_OUT !== 8'h00) begin n_fail++; $display("FAIL reset_dout_s: got %h expected 00", sb.DATA_OUT); end
        n_checks++; if (sb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL reset_empty_s: got %b expected 1", sb.empty_signal); end
        n_checks++; if (sb.full_signal !== 1'b0) begin n_fail++; $display("FAIL reset_full_s: got %b expected 0", sb.full_signal); end
        #1 reset = 1'b0;
        qb.delete(); qs.delete();
        lastb = 8'h00; lasts = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_fill_full();
        pulse_reset();
        for (int i = 0; i < DEPTH_B; i++) begin
            cyc_b(1'b1, 1'b1, i[7:0]);
            if (i == 0) begin
                n_checks++; if (bb.empty_signal !== 1'b0) begin n_fail++; $display("FAIL fill_first_empty: got %b expected 0", bb.empty_signal); end
            end
            if (i == DEPTH_B - 2) begin
                n_checks++; if (bb.full_signal !== 1'b0) begin n_fail++; $display("FAIL fill_nearly_full: got %b expected 0", bb.full_signal); end
            end
        end
        n_checks++; if (bb.full_signal !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", bb.full_signal); end
        cyc_b(1'b1, 1'b1, 8'hAA);
        n_checks++; if (bb.full_signal !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_full: got %b expected 1", bb.full_signal); end
        n_checks++; if (bb.empty_signal !== 1'b0) begin n_fail++; $display("FAIL fill_overflow_empty: got %b expected 0", bb.empty_signal); end
        // Partial drain: an accepted 0xAA would have overwritten word 0.
        for (int i = 0; i < 300; i++) begin
            cyc_b(1'b1, 1'b0, 8'h00);
            n_checks++; if (bb.DATA_OUT !== 8'(i % 256)) begin n_fail++; $display("FAIL big_drain[%0d]: got %h expected %h", i, bb.DATA_OUT, 8'(i % 256)); end
            if (i == 0) begin
                n_checks++; if (bb.full_signal !== 1'b0) begin n_fail++; $display("FAIL big_drain_full: got %b expected 0", bb.full_signal); end
            end
        end
    endtask

    task automatic test_drain();
        pulse_reset();
        for (int i = 0; i < DEPTH_S; i++) cyc_s(1'b1, 1'b1, i[7:0]);
        n_checks++; if (sb.full_signal !== 1'b1) begin n_fail++; $display("FAIL drain_pre_full: got %b expected 1", sb.full_signal); end
        cyc_s(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < DEPTH_S; i++) begin
            cyc_s(1'b1, 1'b0, 8'h00);
            n_checks++; if (sb.DATA_OUT !== i[7:0]) begin n_fail++; $display("FAIL drain[%0d]: got %h expected %h", i, sb.DATA_OUT, i[7:0]); end
        end
        n_checks++; if (sb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", sb.empty_signal); end
        for (int i = 0; i < 3; i++) begin
            cyc_s(1'b1, 1'b0, 8'h00);
            n_checks++; if (sb.DATA_OUT !== EMPTY_POP_VAL) begin n_fail++; $display("FAIL empty_pop[%0d]: got %h expected %h", i, sb.DATA_OUT, EMPTY_POP_VAL); end
            n_checks++; if (sb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL empty_pop_flag[%0d]: got %b expected 1", i, sb.empty_signal); end
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        for (int i = 0; i < 250; i++) cyc_s(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 250; i++) cyc_s(1'b1, 1'b0, 8'h00);
        n_checks++; if (sb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL wrap_mid_empty: got %b expected 1", sb.empty_signal); end
        for (int i = 0; i < 20; i++) cyc_s(1'b1, 1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 20; i++) begin
            cyc_s(1'b1, 1'b0, 8'h00);
            n_checks++; if (sb.DATA_OUT !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, sb.DATA_OUT, 8'(8'h10 + i)); end
        end
        n_checks++; if (sb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL wrap_end_empty: got %b expected 1", sb.empty_signal); end
    endtask

    task automatic test_enable_gating();
        pulse_reset();
        for (int i = 0; i < 5; i++) cyc_b(1'b1, 1'b1, 8'(8'hA0 + i));
        cyc_b(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc_b(1'b0, 1'($urandom), 8'($urandom));
            n_checks++; if (bb.DATA_OUT !== 8'hA0) begin n_fail++; $display("FAIL gate_dout[%0d]: got %h expected a0", i, bb.DATA_OUT); end
            n_checks++; if (bb.empty_signal !== 1'b0 || bb.full_signal !== 1'b0) begin n_fail++; $display("FAIL gate_flags[%0d]: got e%b f%b expected e0 f0", i, bb.empty_signal, bb.full_signal); end
        end
        for (int i = 1; i < 5; i++) begin
            cyc_b(1'b1, 1'b0, 8'h00);
            n_checks++; if (bb.DATA_OUT !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL gate_after[%0d]: got %h expected %h", i, bb.DATA_OUT, 8'(8'hA0 + i)); end
        end
        n_checks++; if (bb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL gate_end_empty: got %b expected 1", bb.empty_signal); end
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        cyc_b(1'b1, 1'b1, 8'h01);
        cyc_b(1'b1, 1'b1, 8'h02);
        cyc_b(1'b1, 1'b1, 8'h03);
        pulse_reset();
        n_checks++; if (bb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b expected 1", bb.empty_signal); end
        cyc_b(1'b1, 1'b1, 8'h55);
        cyc_b(1'b1, 1'b0, 8'h00);
        n_checks++; if (bb.DATA_OUT !== 8'h55) begin n_fail++; $display("FAIL midrst_dout: got %h expected 55", bb.DATA_OUT); end
        n_checks++; if (bb.empty_signal !== 1'b1) begin n_fail++; $display("FAIL midrst_after_empty: got %b expected 1", bb.empty_signal); end
    endtask

    // Phased random traffic: push-heavy then pop-heavy stretches so the small FIFO hits both limits.
    task automatic test_random();
        logic e, p;
        pulse_reset();
        for (int i = 0; i < 2800; i++) begin
            e = ($urandom_range(0, 9) != 0);
            p = ($urandom_range(0, 99) < (((i / 700) % 2 == 0) ? 80 : 20));
            cyc_s(e, p, 8'($urandom));
            n_checks++; if (sb.DATA_OUT !== lasts) begin n_fail++; $display("FAIL rand_s_dout[%0d]: got %h expected %h", i, sb.DATA_OUT, lasts); end
            n_checks++; if (sb.full_signal !== (qs.size() == DEPTH_S) || sb.empty_signal !== (qs.size() == 0)) begin
                n_fail++; $display("FAIL rand_s_flags[%0d]: got f%b e%b expected count %0d", i, sb.full_signal, sb.empty_signal, qs.size());
            end
        end
        for (int i = 0; i < 1500; i++) begin
            e = ($urandom_range(0, 4) != 0);
            p = ($urandom_range(0, 99) < 55);
            cyc_b(e, p, 8'($urandom));
            n_checks++; if (bb.DATA_OUT !== lastb) begin n_fail++; $display("FAIL rand_b_dout[%0d]: got %h expected %h", i, bb.DATA_OUT, lastb); end
            n_checks++; if (bb.full_signal !== (qb.size() == DEPTH_B) || bb.empty_signal !== (qb.size() == 0)) begin
                n_fail++; $display("FAIL rand_b_flags[%0d]: got f%b e%b expected count %0d", i, bb.full_signal, bb.empty_signal, qb.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_drain();
        test_wrap();
        test_enable_gating();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
